// File: rtl/packet_parser_if.sv
// packet_parser_if: upstream byte stream plus parsed header, payload and CRC outputs
interface packet_parser_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        ph_select;
  logic        ph_valid;
  logic [1:0]  virtual_channel;
  logic [5:0]  data_type;
  logic [15:0] word_count;
  logic [7:0]  ecc;
  logic        frame_start;
  logic        frame_end;
  logic        line_start;
  logic        line_end;
  logic [15:0] payload;
  logic [1:0]  payload_be;
  logic        payload_valid;
  logic [15:0] crc;
  logic        crc_valid;
  logic        packet_done;
  logic        err_truncated;
  modport master (
    output in_data, in_valid, ph_select,
    input  ph_valid, virtual_channel, data_type, word_count, ecc,
           frame_start, frame_end, line_start, line_end,
           payload, payload_be, payload_valid, crc, crc_valid, packet_done, err_truncated
  );
  modport slave (
    input  in_data, in_valid, ph_select,
    output ph_valid, virtual_channel, data_type, word_count, ecc,
           frame_start, frame_end, line_start, line_end,
           payload, payload_be, payload_valid, crc, crc_valid, packet_done, err_truncated
  );
endinterface

// File: rtl/packet_parser.sv
// packet_parser: splits a CSI-2 style byte stream into header fields, payload bytes and CRC
module packet_parser (
  input logic        rxbyteclkhs,
  input logic        reset,
  packet_parser_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PAYLOAD, CRC_LO, CRC_HI, DRAIN} state_e;
  typedef struct packed {
    logic        ph_valid;
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    logic [7:0]  ecc;
    logic        fs, fe, ls, le;
    logic [15:0] payload;
    logic [1:0]  be;
    logic        pv;
    logic [15:0] crc;
    logic        crc_valid, done, err;
  } out_t;
  state_e      state_q, state_d;
  logic [15:0] rem_q, rem_d;
  out_t        o_q, o_d;
  logic        v, hdr, short_pkt, two_left;
  logic [15:0] wc_in, rem_m2;
  logic [15:0] hi;
  assign v         = bus.in_valid;
  assign hdr       = v & bus.ph_select;
  assign short_pkt = bus.in_data[5:4] == 2'b00;
  assign wc_in     = bus.in_data[23:8];
  assign hi        = bus.in_data[31:16];
  assign two_left  = |rem_q[15:1];
  assign rem_m2    = rem_q - 16'd2;
  always_ff @(posedge rxbyteclkhs or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      o_q     <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      o_q     <= o_d;
    end
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: if (hdr) begin
        state_d = short_pkt ? DRAIN : (wc_in == 16'd0 ? CRC_LO : PAYLOAD);
        rem_d   = short_pkt ? 16'd0 : wc_in;
      end
      PAYLOAD: if (!v) state_d = IDLE;
        else if (two_left) begin
          rem_d   = rem_m2;
          state_d = rem_m2 == 16'd0 ? CRC_LO : PAYLOAD;
        end else begin
          rem_d   = '0;
          state_d = CRC_HI;
        end
      CRC_LO, CRC_HI: state_d = v ? DRAIN : IDLE;
      DRAIN: state_d = v ? DRAIN : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // header fields and crc hold between updates; everything else is a one-cycle pulse
  always_comb begin
    o_d = o_q;
    {o_d.ph_valid, o_d.fs, o_d.fe, o_d.ls, o_d.le, o_d.be, o_d.pv,
     o_d.crc_valid, o_d.done, o_d.err} = '0;
    case (state_q)
      IDLE: if (hdr) begin
        o_d.ph_valid = 1'b1;
        o_d.dt       = bus.in_data[5:0];
        o_d.vc       = bus.in_data[7:6];
        o_d.wc       = wc_in;
        o_d.ecc      = bus.in_data[31:24];
        o_d.fs       = bus.in_data[5:0] == 6'h00;
        o_d.fe       = bus.in_data[5:0] == 6'h01;
        o_d.ls       = bus.in_data[5:0] == 6'h02;
        o_d.le       = bus.in_data[5:0] == 6'h03;
        o_d.done     = short_pkt;
      end
      PAYLOAD: if (!v) o_d.err = 1'b1;
        else begin
          o_d.pv      = 1'b1;
          o_d.payload = two_left ? hi : {8'h00, hi[7:0]};
          o_d.be      = two_left ? 2'b11 : 2'b01;
          if (!two_left) o_d.crc[7:0] = hi[15:8];
        end
      CRC_LO: if (!v) o_d.err = 1'b1;
        else begin
          o_d.crc       = hi;
          o_d.crc_valid = 1'b1;
          o_d.done      = 1'b1;
        end
      CRC_HI: if (!v) o_d.err = 1'b1;
        else begin
          o_d.crc[15:8] = hi[7:0];
          o_d.crc_valid = 1'b1;
          o_d.done      = 1'b1;
        end
      default: ;
    endcase
  end
  assign bus.ph_valid        = o_q.ph_valid;
  assign bus.virtual_channel = o_q.vc;
  assign bus.data_type       = o_q.dt;
  assign bus.word_count      = o_q.wc;
  assign bus.ecc             = o_q.ecc;
  assign bus.frame_start     = o_q.fs;
  assign bus.frame_end       = o_q.fe;
  assign bus.line_start      = o_q.ls;
  assign bus.line_end        = o_q.le;
  assign bus.payload         = o_q.payload;
  assign bus.payload_be      = o_q.be;
  assign bus.payload_valid   = o_q.pv;
  assign bus.crc             = o_q.crc;
  assign bus.crc_valid       = o_q.crc_valid;
  assign bus.packet_done     = o_q.done;
  assign bus.err_truncated   = o_q.err;
endmodule

// File: doc/packet_parser.md
PACKET_PARSER -- requirements
Module: packet_parser

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 rxbyteclkhs  input  1  byte clock; the only clock; all state is on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_data  input  32  upstream word; on the header cycle it holds {ECC, WC[15:8], WC[7:0], DI}; on later cycles only in_data[31:16] carries stream bytes, with [23:16] the earlier byte and [31:24] the later byte.
REQ-005 in_valid  input  1  upstream word valid; low means the upstream burst has ended.
REQ-006 ph_select  input  1  high with in_valid when in_data holds the packet header.
REQ-007 ph_valid  output  1  one-cycle pulse; the header fields below have been updated.
REQ-008 virtual_channel  output  2  DI[7:6] of the last header.
REQ-009 data_type  output  6  DI[5:0] of the last header.
REQ-010 word_count  output  16  WC of the last header.
REQ-011 ecc  output  8  ECC byte of the last header; it is passed through and not checked.
REQ-012 frame_start, frame_end, line_start, line_end  output  1 each  one-cycle pulses for short packets.
REQ-013 payload  output  16  payload bytes; [7:0] is the earlier byte.
REQ-014 payload_be  output  2  byte enables for payload; valid only with payload_valid.
REQ-015 payload_valid  output  1  payload/payload_be are valid this cycle.
REQ-016 crc  output  16  received packet CRC {later byte, earlier byte}; held until the next crc_valid.
REQ-017 crc_valid  output  1  one-cycle pulse; crc has been updated.
REQ-018 packet_done  output  1  one-cycle pulse; the packet has been fully consumed.
REQ-019 err_truncated  output  1  one-cycle pulse; in_valid fell before the packet was complete.

Function
REQ-020 All outputs SHALL be registered, with exactly one cycle of latency from the consuming input cycle.
REQ-021 States SHALL be IDLE, PAYLOAD, CRC_LO, CRC_HI and DRAIN.
REQ-022 IDLE, on in_valid&ph_select: latch the header fields and pulse ph_valid.
  - If data_type<=6'h0F (short packet): pulse FS/FE/LS/LE for DT 0x00/0x01/0x02/0x03 respectively, or no sync pulse for 0x04-0x0F; also pulse packet_done; go to DRAIN.
  - Otherwise (long packet): load remaining=WC; go to PAYLOAD if WC!=0, or to CRC_LO if WC==0.
REQ-023 IDLE: in_valid without ph_select SHALL be ignored.
REQ-024 PAYLOAD, per in_valid cycle:
  - remaining>=2: payload=in_data[31:16], payload_be=2'b11, payload_valid=1, remaining-=2; go to CRC_LO when the result is 0.
  - remaining==1: payload[7:0]=in_data[23:16], payload_be=2'b01, payload_valid=1; crc[7:0]=in_data[31:24]; go to CRC_HI.
REQ-025 CRC_LO, per in_valid cycle: crc={in_data[31:24],in_data[23:16]}; pulse crc_valid and packet_done; go to DRAIN.
REQ-026 CRC_HI, per in_valid cycle: crc[15:8]=in_data[23:16]; pulse crc_valid and packet_done; go to DRAIN.
REQ-027 DRAIN SHALL ignore all input while in_valid=1 and SHALL go to IDLE the cycle in_valid=0.
REQ-028 In IDLE or DRAIN, in_valid=0 SHALL produce no pulses.
REQ-029 In PAYLOAD, CRC_LO or CRC_HI, in_valid=0 SHALL pulse err_truncated, produce no payload or CRC output, and go to IDLE.
REQ-030 ph_select outside IDLE SHALL be ignored.
REQ-031 remaining SHALL be 16 bits unsigned and SHALL never underflow.
REQ-032 payload_be SHALL be 2'b00 whenever payload_valid=0.
REQ-033 All pulse outputs SHALL be high for exactly one cycle per event.
REQ-034 At most one of frame_start, frame_end, line_start, line_end SHALL be high in any cycle.

Reset
REQ-035 reset=1 SHALL asynchronously force state=IDLE and remaining=0.
REQ-036 reset=1 SHALL asynchronously force every output and header/crc register to 0.
REQ-037 A reset asserted mid-packet SHALL discard the packet without pulsing err_truncated or packet_done.
REQ-038 After reset deassertion, a header SHALL be accepted in the first cycle with in_valid&ph_select.

Verification
REQ-039 Short FS: header 32'h5A_00_05_00 (DI=00, WC=0x0005) -> next cycle ph_valid=1, frame_start=1, packet_done=1, data_type=0, word_count=5, ecc=8'h5A; no payload_valid.
REQ-040 Long even: DI=8'h6A (VC1, DT 0x2A), WC=4, then upper halves 16'h2211, 16'h4433, 16'hBEEF -> payload 16'h2211/be=11, then 16'h4433/be=11, then crc=16'hBEEF with crc_valid and packet_done.
REQ-041 Long odd: WC=3, then upper halves 16'h2211, 16'hCD33, 16'h00AB -> payload 2211/11, then payload[7:0]=33 with be=01, then crc=16'hABCD with crc_valid and packet_done.
REQ-042 Truncation: WC=8, in_valid drops after 2 payload words -> err_truncated pulse, no packet_done, state IDLE; the next header is parsed normally.
REQ-043 WC=0 long packet: header, then CRC word 16'h1234 -> no payload_valid; crc=16'h1234 with packet_done.
REQ-044 Async reset mid-PAYLOAD: all outputs 0 immediately without waiting for a clock edge; no pulses follow; a new header after release parses correctly.
